rr_burst_arbiter: RTL and testbench

N-way round-robin arbiter that shares one bus/resource between up to N requesters and extends the existing two-input fixed arbiter to fairness plus bounded ownership. Each grant is held until the owner signals done, drops its request, or exhausts a per-grant hold budget. Every release is followed by one mandatory dead cycle before the next grant. The block sits between requester masters and the shared resource mux; gnt_id drives the mux select directly.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 38 +++
 rtl/rr_burst_arbiter.sv | 119 +++++++++++
 tb/tb_rr_burst_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin burst arbiter family.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 8;

  // Width helper that never returns 0, so a 2-entry index still gets one bit.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: the first set req at or after ptr wins,
// searching ptr..N-1 and then wrapping to 0..ptr-1.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = clog2w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] win_id
);

  localparam int PW = IDW + 1;

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] masked;

  assign dbl_req = {req, req};

  // The upper copy is never masked, so the wrap-around part of the search
  // falls out of a plain lowest-bit-first encode over the doubled vector.
  for (genvar gi = 0; gi < 2 * N; gi++) begin : g_mask
    assign masked[gi] = dbl_req[gi] & (PW'(gi) >= {1'b0, ptr});
  end

  always_comb begin
    any    = |req;
    win_id = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        win_id = IDW'(i % N);
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-way round-robin arbiter with bounded ownership and a one-cycle dead gap
// after every release. All outputs come straight from flops.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int IDW      = clog2w(N)
) (
  input  logic           clk,
  input  logic           rest_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  // Sized for MAX_HOLD itself so the budget compare happens before any wrap.
  localparam int HW = clog2w(MAX_HOLD + 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           pick_any;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] next_ptr;
  logic           rel_done, rel_drop, rel_max;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .win_id (pick_id)
  );

  // Only the current owner's strobes matter; gnt_id_q is the owner in GRANT.
  assign rel_done = done[gnt_id_q];
  assign rel_drop = ~req[gnt_id_q];
  assign rel_max  = (hold_q == HW'(MAX_HOLD));
  assign next_ptr = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[pick_id]  = 1'b1;
          gnt_id_d        = pick_id;
          busy_d          = 1'b1;
          hold_d          = HW'(1);
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_max) begin
          state_d   = GAP;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = next_ptr;
          timeout_d = rel_max && !rel_done && !rel_drop;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scenario bench for rr_burst_arbiter (N=4, MAX_HOLD=4): per-cycle expected
// outputs go through a scoreboard queue and are compared after each edge.
module tb_rr_burst_arbiter;

  logic       clk;
  logic       rest_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  logic [7:0] obs;
  logic [7:0] sb [$];
  int checks;
  int errors;

  rr_burst_arbiter #(
    .N        (4),
    .MAX_HOLD (4),
    .IDW      (2)
  ) dut (
    .clk     (clk),
    .rest_n  (rest_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  assign obs = {gnt, gnt_id, busy, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row layout: {req, done, exp_gnt, exp_id, exp_busy, exp_timeout}.
  function automatic logic [15:0] row(input logic [3:0] rq, input logic [3:0] dn,
                                      input logic [3:0] g, input logic [1:0] id,
                                      input logic b, input logic t);
    return {rq, dn, g, id, b, t};
  endfunction

  task automatic test_reset();
    logic [15:0] rows_a [5];
    logic [15:0] rows_b [3];
    logic [7:0]  exp;
    rest_n = 1'b0;
    req    = '0;
    done   = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b id=%0d busy=%b to=%b, want all zero",
               gnt, gnt_id, busy, timeout);
    end
    @(negedge clk);
    rest_n = 1'b1;
    rows_a = '{row(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0),
               row(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0),
               row(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0),
               row(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0),
               row(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      req = rows_a[i][15:12];
      done = rows_a[i][11:8];
      sb.push_back(rows_a[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("reset_a row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_a row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
    // Asynchronous reset in the middle of owner 2's grant.
    #2;
    rest_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_grant: got gnt=%b id=%0d busy=%b to=%b, want all zero",
               gnt, gnt_id, busy, timeout);
    end
    #2;
    rest_n = 1'b1;
    // With ptr back at 0, requester 0 must beat the still-requesting old owner 2.
    rows_b = '{row(4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
               row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0),
               row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 3; i++) begin
      req = rows_b[i][15:12];
      done = rows_b[i][11:8];
      sb.push_back(rows_b[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("reset_b row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_b row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
  endtask

  // Starts with ptr=1.
  task automatic test_single_done();
    logic [15:0] rows [8];
    logic [7:0]  exp;
    rows = '{row(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0),
             row(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0),
             row(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0),
             row(4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0),
             row(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 8; i++) begin
      req = rows[i][15:12];
      done = rows[i][11:8];
      sb.push_back(rows[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("single_done row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_done row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
  endtask

  // Starts with ptr=1.
  task automatic test_hold_budget();
    logic [15:0] rows [9];
    logic [7:0]  exp;
    rows = '{row(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
             row(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
             row(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
             row(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
             row(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1),
             row(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0),
             row(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 9; i++) begin
      req = rows[i][15:12];
      done = rows[i][11:8];
      sb.push_back(rows[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("hold_budget row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold_budget row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
  endtask

  // Starts with ptr=1; a short grant to owner 3 moves ptr to 0 first.
  task automatic test_fairness();
    logic [15:0] rows [$];
    logic [7:0]  exp;
    int          order [5];
    logic [3:0]  g;
    order = '{0, 1, 2, 3, 0};
    rows.push_back(row(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0));
    rows.push_back(row(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0));
    rows.push_back(row(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0));
    for (int o = 0; o < 5; o++) begin
      g = 4'b0001 << order[o];
      for (int k = 0; k < 4; k++)
        rows.push_back(row(4'b1111, 4'b0000, g, 2'(order[o]), 1'b1, 1'b0));
      rows.push_back(row(4'b1111, 4'b0000, 4'b0000, 2'(order[o]), 1'b0, 1'b1));
      rows.push_back(row(4'b1111, 4'b0000, 4'b0000, 2'(order[o]), 1'b0, 1'b0));
    end
    rows[rows.size() - 1][15:12] = 4'b0000;
    rows.push_back(row(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < rows.size(); i++) begin
      req = rows[i][15:12];
      done = rows[i][11:8];
      sb.push_back(rows[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("fairness row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL fairness row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
  endtask

  // Starts with ptr=1; owner 2 sees non-owner strobes, then done at the budget.
  task automatic test_ignored_inputs();
    logic [15:0] rows [9];
    logic [7:0]  exp;
    rows = '{row(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0),
             row(4'b0100, 4'b1000, 4'b0100, 2'd2, 1'b1, 1'b0),
             row(4'b1100, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0),
             row(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0),
             row(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0),
             row(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0),
             row(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0)};
    for (int i = 0; i < 9; i++) begin
      req = rows[i][15:12];
      done = rows[i][11:8];
      sb.push_back(rows[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("ignored row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL ignored row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
  endtask

  // Starts with ptr=3: search wraps 3,0,1 to find 1, then 2 is next.
  task automatic test_wrap_pick();
    logic [15:0] rows [6];
    logic [7:0]  exp;
    rows = '{row(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0),
             row(4'b0110, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0),
             row(4'b0110, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0),
             row(4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0),
             row(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      req = rows[i][15:12];
      done = rows[i][11:8];
      sb.push_back(rows[i][7:0]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      $display("wrap_pick row %0d req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
               i, req, done, gnt, gnt_id, busy, timeout);
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap_pick row %0d: got %b, want %b (gnt,id,busy,to)", i, obs, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_done();
    test_hold_budget();
    test_fairness();
    test_ignored_inputs();
    test_wrap_pick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
